// File: rtl/regfile_sb_pkg.sv
// Shared constants, types and the address decode helper for the
// scoreboarded register file.
package regfile_sb_pkg;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int CNT_W  = ADDR_W + 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] idx_t;
    typedef logic [NREG-1:0]   onehot_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam idx_t    R0_IDX      = 5'd0;
    localparam word_t   WORD_ZERO   = 20'h00000;
    localparam onehot_t ONEHOT_NONE = 32'h0000_0000;
    localparam onehot_t ONEHOT_ALL  = 32'hFFFF_FFFF;
    localparam cnt_t    CNT_ZERO    = 6'd0;

    // 5-to-32 one-hot decode shared by the write enables and the scoreboard masks
    function automatic onehot_t decode(input idx_t a);
        onehot_t m;
        m    = ONEHOT_NONE;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, reserve and writeback bundle between issue/writeback logic (master)
// and the register file (slave).
interface regfile_sb_if;
    import regfile_sb_pkg::*;

    idx_t    rd_addr_a;
    word_t   rd_data_a;
    logic    rd_busy_a;
    idx_t    rd_addr_b;
    word_t   rd_data_b;
    logic    rd_busy_b;
    logic    rsv_valid;
    idx_t    rsv_addr;
    logic    rsv_ready;
    logic    wr_valid;
    idx_t    wr_addr;
    word_t   wr_data;
    onehot_t busy_vec;
    cnt_t    busy_cnt;
    logic    wr_err;

    modport master (
        output rd_addr_a, rd_addr_b, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
        input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ready,
               busy_vec, busy_cnt, wr_err
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rsv_ready,
               busy_vec, busy_cnt, wr_err
    );

endinterface

// File: rtl/regfile_sb_score.sv
// Busy scoreboard: per-register busy bits, their population count, the
// sticky stray-write flag, reserve acceptance and busy read-out.
module regfile_sb_score
    import regfile_sb_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  idx_t    rd_addr_a,
    input  idx_t    rd_addr_b,
    input  logic    rsv_valid,
    input  idx_t    rsv_addr,
    input  logic    wr_valid,
    input  idx_t    wr_addr,
    output logic    rsv_ready,
    output logic    rd_busy_a,
    output logic    rd_busy_b,
    output onehot_t busy_vec,
    output cnt_t    busy_cnt,
    output logic    wr_err
);

    onehot_t busy_r;
    cnt_t    cnt_r;
    logic    err_r;

    logic    rsv_r0_s;
    logic    wr_r0_s;
    logic    wr_hit_rsv_s;
    logic    set_s;
    logic    clr_s;
    logic    err_set_s;
    onehot_t set_mask_s;
    onehot_t clr_mask_s;

    // Reserve acceptance, set/clear masks and busy read-out with write bypass
    always_comb begin
        rsv_r0_s     = R0_ZERO && (rsv_addr == R0_IDX);
        wr_r0_s      = R0_ZERO && (wr_addr == R0_IDX);
        wr_hit_rsv_s = wr_valid && (wr_addr == rsv_addr);
        // A same-cycle writeback frees the register, so the reserve may take it over
        rsv_ready    = rsv_valid && (rsv_r0_s || !busy_r[rsv_addr] || wr_hit_rsv_s);
        set_s        = rsv_ready && !rsv_r0_s;
        clr_s        = wr_valid && busy_r[wr_addr];
        err_set_s    = wr_valid && !busy_r[wr_addr] && !wr_r0_s;
        set_mask_s   = set_s ? decode(rsv_addr) : ONEHOT_NONE;
        clr_mask_s   = wr_valid ? decode(wr_addr) : ONEHOT_NONE;
        rd_busy_a    = busy_r[rd_addr_a] && !(wr_valid && (wr_addr == rd_addr_a));
        rd_busy_b    = busy_r[rd_addr_b] && !(wr_valid && (wr_addr == rd_addr_b));
    end

    // Scoreboard state; clear is applied before set so a same-address pair nets busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= ONEHOT_NONE;
            cnt_r  <= CNT_ZERO;
            err_r  <= 1'b0;
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
            cnt_r  <= cnt_r + cnt_t'(set_s) - cnt_t'(clr_s);
            err_r  <= err_r | err_set_s;
        end
    end

    assign busy_vec = busy_r;
    assign busy_cnt = cnt_r;
    assign wr_err   = err_r;

endmodule

// File: rtl/regfile_sb.sv
// 32 x 20-bit register file with decoded writes, 32:1 read selection,
// write-first bypass and a per-register busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    word_t   regs_r [NREG];
    onehot_t wr_en_s;
    onehot_t r0_mask_s;
    word_t   rd_data_a_s;
    word_t   rd_data_b_s;

    // One-hot write enables with register 0 masked off when it is hardwired
    always_comb begin
        r0_mask_s = R0_ZERO ? ~decode(R0_IDX) : ONEHOT_ALL;
        wr_en_s   = (bus.wr_valid ? decode(bus.wr_addr) : ONEHOT_NONE) & r0_mask_s;
    end

    // Data array storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_r[i] <= WORD_ZERO;
            end else if (wr_en_s[i]) begin
                regs_r[i] <= bus.wr_data;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Read selection: hardwired zero first, then same-cycle write, then storage
    always_comb begin
        if (R0_ZERO && (bus.rd_addr_a == R0_IDX)) begin
            rd_data_a_s = WORD_ZERO;
        end else if (bus.wr_valid && (bus.wr_addr == bus.rd_addr_a)) begin
            rd_data_a_s = bus.wr_data;
        end else begin
            rd_data_a_s = regs_r[bus.rd_addr_a];
        end

        if (R0_ZERO && (bus.rd_addr_b == R0_IDX)) begin
            rd_data_b_s = WORD_ZERO;
        end else if (bus.wr_valid && (bus.wr_addr == bus.rd_addr_b)) begin
            rd_data_b_s = bus.wr_data;
        end else begin
            rd_data_b_s = regs_r[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a = rd_data_a_s;
    assign bus.rd_data_b = rd_data_b_s;

    regfile_sb_score #(
        .R0_ZERO (R0_ZERO)
    ) u_score (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (bus.rd_addr_a),
        .rd_addr_b (bus.rd_addr_b),
        .rsv_valid (bus.rsv_valid),
        .rsv_addr  (bus.rsv_addr),
        .wr_valid  (bus.wr_valid),
        .wr_addr   (bus.wr_addr),
        .rsv_ready (bus.rsv_ready),
        .rd_busy_a (bus.rd_busy_a),
        .rd_busy_b (bus.rd_busy_b),
        .busy_vec  (bus.busy_vec),
        .busy_cnt  (bus.busy_cnt),
        .wr_err    (bus.wr_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: reset, reserve/write, bypass,
// refused reserve, stray write, register 0 and reset during a fill.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regfile_sb_if bus ();

    regfile_sb #(
        .R0_ZERO (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rsv_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.rsv_addr  = 5'd0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 20'h00000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.busy_cnt); end
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_vec: got %h expected 0", bus.busy_vec); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.wr_err); end
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(31 - i);
            #1;
            checks++; if (bus.rd_data_a !== 20'h00000 || bus.rd_busy_a !== 1'b0) begin errors++; $display("FAIL reset_rd_a[%0d]: got %h/%b expected 00000/0", i, bus.rd_data_a, bus.rd_busy_a); end
            checks++; if (bus.rd_data_b !== 20'h00000 || bus.rd_busy_b !== 1'b0) begin errors++; $display("FAIL reset_rd_b[%0d]: got %h/%b expected 00000/0", 31 - i, bus.rd_data_b, bus.rd_busy_b); end
        end
    endtask

    task automatic test_reserve_write();
        bus.rd_addr_a = 5'd5;
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd5;
        #1;
        checks++; if (bus.rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv5_ready: got %b expected 1", bus.rsv_ready); end
        checks++; if (bus.rd_busy_a !== 1'b0) begin errors++; $display("FAIL rsv5_busy_same_cycle: got %b expected 0", bus.rd_busy_a); end
        tick();
        bus.rsv_valid = 1'b0;
        #1;
        checks++; if (bus.rd_busy_a !== 1'b1) begin errors++; $display("FAIL rsv5_busy: got %b expected 1", bus.rd_busy_a); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv5_cnt: got %0d expected 1", bus.busy_cnt); end
        checks++; if (bus.busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL rsv5_vec: got %h expected 00000020", bus.busy_vec); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 20'hABCDE;
        #1;
        checks++; if (bus.rd_data_a !== 20'hABCDE) begin errors++; $display("FAIL wr5_bypass_data: got %h expected abcde", bus.rd_data_a); end
        checks++; if (bus.rd_busy_a !== 1'b0) begin errors++; $display("FAIL wr5_bypass_busy: got %b expected 0", bus.rd_busy_a); end
        tick();
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL wr5_cnt: got %0d expected 0", bus.busy_cnt); end
        checks++; if (bus.rd_data_a !== 20'hABCDE) begin errors++; $display("FAIL wr5_stored: got %h expected abcde", bus.rd_data_a); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr5_err: got %b expected 0", bus.wr_err); end
    endtask

    task automatic test_double_reserve();
        bus.rd_addr_a = 5'd7;
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd7;
        tick();
        #1;
        checks++; if (bus.rsv_ready !== 1'b0) begin errors++; $display("FAIL rsv7_second_ready: got %b expected 0", bus.rsv_ready); end
        tick();
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv7_refused_cnt: got %0d expected 1", bus.busy_cnt); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd7;
        bus.wr_data  = 20'h00011;
        #1;
        checks++; if (bus.rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv7_with_wr_ready: got %b expected 1", bus.rsv_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.rd_busy_a !== 1'b1) begin errors++; $display("FAIL rsv7_net_busy: got %b expected 1", bus.rd_busy_a); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv7_net_cnt: got %0d expected 1", bus.busy_cnt); end
        checks++; if (bus.rd_data_a !== 20'h00011) begin errors++; $display("FAIL rsv7_data: got %h expected 00011", bus.rd_data_a); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL rsv7_err: got %b expected 0", bus.wr_err); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd7;
        bus.wr_data  = 20'h00022;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.busy_cnt !== 6'd0 || bus.rd_data_a !== 20'h00022) begin errors++; $display("FAIL rsv7_release: got cnt=%0d data=%h expected 0/00022", bus.busy_cnt, bus.rd_data_a); end
    endtask

    task automatic test_back_to_back();
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd9;
        tick();
        bus.rsv_addr  = 5'd10;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 5'd9;
        bus.wr_data   = 20'h0AAAA;
        #1;
        checks++; if (bus.rsv_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.rsv_ready); end
        tick();
        idle_inputs();
        bus.rd_addr_a = 5'd9;
        bus.rd_addr_b = 5'd10;
        #1;
        checks++; if (bus.busy_vec !== 32'h0000_0400) begin errors++; $display("FAIL b2b_vec: got %h expected 00000400", bus.busy_vec); end
        checks++; if (bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL b2b_cnt: got %0d expected 1", bus.busy_cnt); end
        checks++; if (bus.rd_data_a !== 20'h0AAAA) begin errors++; $display("FAIL b2b_r9: got %h expected 0aaaa", bus.rd_data_a); end
        checks++; if (bus.rd_busy_b !== 1'b1) begin errors++; $display("FAIL b2b_r10_busy: got %b expected 1", bus.rd_busy_b); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd10;
        bus.wr_data  = 20'h0BBBB;
        #1;
        checks++; if (bus.rd_data_b !== 20'h0BBBB || bus.rd_busy_b !== 1'b0) begin errors++; $display("FAIL b2b_bypass_b: got %h/%b expected 0bbbb/0", bus.rd_data_b, bus.rd_busy_b); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.busy_cnt !== 6'd0 || bus.wr_err !== 1'b0) begin errors++; $display("FAIL b2b_done: got cnt=%0d err=%b expected 0/0", bus.busy_cnt, bus.wr_err); end
    endtask

    task automatic test_r0();
        bus.rd_addr_a = 5'd0;
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd0;
        #1;
        checks++; if (bus.rsv_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b expected 1", bus.rsv_ready); end
        tick();
        bus.rsv_valid = 1'b0;
        #1;
        checks++; if (bus.busy_vec !== 32'h0 || bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL r0_busy: got vec=%h cnt=%0d expected 0/0", bus.busy_vec, bus.busy_cnt); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 20'hFFFFF;
        #1;
        checks++; if (bus.rd_data_a !== 20'h00000) begin errors++; $display("FAIL r0_no_bypass: got %h expected 00000", bus.rd_data_a); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.rd_data_a !== 20'h00000) begin errors++; $display("FAIL r0_stored: got %h expected 00000", bus.rd_data_a); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL r0_err: got %b expected 0", bus.wr_err); end
    endtask

    task automatic test_wr_err();
        bus.rd_addr_b = 5'd3;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 5'd3;
        bus.wr_data   = 20'h12345;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.wr_err); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d]: got %b expected 1", i, bus.wr_err); end
        end
        checks++; if (bus.rd_data_b !== 20'h12345) begin errors++; $display("FAIL err_data: got %h expected 12345", bus.rd_data_b); end
        checks++; if (bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL err_cnt: got %0d expected 0", bus.busy_cnt); end
    endtask

    task automatic test_fill_reset();
        bus.rsv_valid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.rsv_addr = 5'(i);
            #1;
            checks++; if (bus.rsv_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.rsv_ready); end
            tick();
        end
        bus.rsv_valid = 1'b0;
        #1;
        checks++; if (bus.busy_cnt !== 6'd31) begin errors++; $display("FAIL fill_cnt: got %0d expected 31", bus.busy_cnt); end
        checks++; if (bus.busy_vec !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fill_vec: got %h expected fffffffe", bus.busy_vec); end
        rst = 1'b1;
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd4;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 5'd2;
        bus.wr_data   = 20'h55555;
        tick();
        rst = 1'b0;
        idle_inputs();
        bus.rd_addr_a = 5'd2;
        bus.rd_addr_b = 5'd3;
        #1;
        checks++; if (bus.busy_vec !== 32'h0 || bus.busy_cnt !== 6'd0) begin errors++; $display("FAIL rst_mid: got vec=%h cnt=%0d expected 0/0", bus.busy_vec, bus.busy_cnt); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", bus.wr_err); end
        checks++; if (bus.rd_data_a !== 20'h00000 || bus.rd_data_b !== 20'h00000) begin errors++; $display("FAIL rst_mid_data: got %h/%h expected 00000/00000", bus.rd_data_a, bus.rd_data_b); end
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd4;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.busy_vec !== 32'h0000_0010 || bus.busy_cnt !== 6'd1) begin errors++; $display("FAIL post_rst_rsv: got vec=%h cnt=%0d expected 00000010/1", bus.busy_vec, bus.busy_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd0;
        idle_inputs();
        test_reset();
        test_reserve_write();
        test_double_reserve();
        test_back_to_back();
        test_r0();
        test_wr_err();
        test_fill_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
